// File: rtl/sipo_deser.sv
// Serial-in / parallel-out deserializer with selectable bit order.
// Bits are accepted on a valid/ready handshake and collected into a partial
// word. A completed word moves into a holding register (data_out) that is
// drained with out_valid/out_ready. A word can be popped and the next word
// loaded on the same edge, so back-to-back words need no idle cycle.
// flush discards only the partial word. A word that is held in data_out
// is kept.
module sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int CW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             serial_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    bit_count
);

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             out_valid_q, out_valid_d;
    logic [CW-1:0]    bit_count_q, bit_count_d;

    logic [CW-1:0]    idx_s;
    logic [WIDTH-1:0] word_s;
    logic             last_s;
    logic             in_ready_s;
    logic             accept_s;

    // Word position of the incoming bit, and the word as it would look with that bit inserted
    always_comb begin
        if (MSB_FIRST) begin
            idx_s = LAST_CNT - bit_count_q;
        end else begin
            idx_s = bit_count_q;
        end
        word_s        = shift_q;
        word_s[idx_s] = serial_in;
    end

    // Handshake: stall only the completing bit while an unconsumed word is held
    always_comb begin
        last_s     = (bit_count_q == LAST_CNT);
        in_ready_s = !flush && !(last_s && out_valid_q && !out_ready);
        accept_s   = in_valid && in_ready_s;
    end

    // Next-state for the partial word, the bit count and the output holding register
    always_comb begin
        shift_d     = shift_q;
        bit_count_d = bit_count_q;
        data_out_d  = data_out_q;
        out_valid_d = out_valid_q;

        // A pop clears out_valid. A word that completes on the same edge sets it again below.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (flush) begin
            shift_d     = '0;
            bit_count_d = '0;
        end else if (accept_s) begin
            if (last_s) begin
                data_out_d  = word_s;
                out_valid_d = 1'b1;
                shift_d     = '0;
                bit_count_d = '0;
            end else begin
                shift_d     = word_s;
                bit_count_d = bit_count_q + CW'(1);
            end
        end else begin
            shift_d     = shift_q;
            bit_count_d = bit_count_q;
        end
    end

    // State registers, cleared asynchronously by reset_b
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            shift_q     <= '0;
            bit_count_q <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_count_q <= bit_count_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign bit_count = bit_count_q;

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Parametrised serial-in/parallel-out deserializer; next generation of the team's 8-bit SIPO converter.
- Generalised word width and selectable bit order.
- Valid/ready handshake on both sides; output holding register allows zero-bubble back-to-back words.
- Synchronous flush of a partial word.
- Sits between a bit-serial link receiver and word-wide downstream logic.

Parameters:
- WIDTH, 8, parallel word width in bits; legal range 2..64.
- MSB_FIRST, 0, 0: first received bit lands in data_out[0]; 1: first received bit lands in data_out[WIDTH-1].

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset_b  input  1  asynchronous, active-low reset.
- serial_in  input  1  serial data bit, sampled when in_valid && in_ready.
- in_valid  input  1  upstream asserts when serial_in holds a valid bit.
- in_ready  output  1  block can accept a bit this cycle (combinational).
- flush  input  1  synchronous discard of the partial word.
- data_out  output  WIDTH  completed parallel word (registered).
- out_valid  output  1  data_out holds an unconsumed word.
- out_ready  input  1  downstream accepts data_out this cycle.
- bit_count  output  CW  number of bits in the partial word, CW = $clog2(WIDTH).

Behaviour:
- Reset, asynchronous on reset_b low, effective immediately and independent of clk:
  - data_out = 0, out_valid = 0, bit_count = 0, internal shift register = 0.
  - Any partial word and any held word are lost.
  - First bit accepted after release is bit 0 of a new word.
- Bit accept: a bit is taken when in_valid && in_ready at a rising edge.
  - LSB-first (MSB_FIRST=0): bit k of the word = k-th accepted bit.
  - MSB-first (MSB_FIRST=1): bit WIDTH-1-k of the word = k-th accepted bit.
  - bit_count increments by 1 per accepted bit; it holds during in_valid gaps.
- Word completion: accepting a bit while bit_count == WIDTH-1:
  - The assembled word (including this bit) is loaded into data_out.
  - out_valid = 1 and bit_count = 0 from the next cycle.
  - Latency: last bit sampled at edge N -> out_valid high after edge N.
- Output pop: out_valid && out_ready at an edge clears out_valid, unless a new word loads at the same edge.
  - In that case out_valid stays 1 and data_out takes the new word, giving continuous throughput.
- Back-pressure: in_ready = !flush && !(bit_count == WIDTH-1 && out_valid && !out_ready).
  - Partial-word accumulation continues while a held word waits.
  - Only the completing bit is stalled; data_out is never overwritten while unconsumed.
- Flush, synchronous:
  - At an edge with flush = 1, bit_count and the shift register clear.
  - in_ready is 0 while flush is high, so a simultaneous bit is not accepted.
  - data_out and out_valid are unaffected; a held word can still be popped in the same cycle.
- States, implicit in bit_count and out_valid: EMPTY (cnt=0, !ov), FILLING (cnt>0, !ov), HELD (ov, any cnt), STALL (ov, cnt=WIDTH-1, !out_ready). Transitions follow the rules above.
- No X propagation: serial_in is ignored unless accepted. data_out keeps its last value after a pop.

Test Plan:
1. WIDTH=8, MSB_FIRST=0, out_ready=1, bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles -> data_out=8'h4D, out_valid high exactly 1 cycle after 8th edge. Same stimulus with MSB_FIRST=1 -> 8'hB2.
2. out_ready=0, stream 0xA5 then 0x3C LSB-first -> out_valid=1, data_out=0xA5 held; bit_count reaches 7 and in_ready drops with the 16th bit pending. Raise out_ready -> pop and load on the same edge; out_valid stays 1, data_out=0x3C.
3. Continuous stream of 4 words with out_ready=1 -> one word every 8 cycles, in_ready never low, no bubbles.
4. Random in_valid gaps (50%) while sending 0x96 -> bit_count holds during gaps; final data_out=0x96.
5. 5 bits sent, then flush=1 with in_valid=1 for 1 cycle -> bit_count=0, that bit dropped. Next 8 bits form a clean word; a previously held word is unchanged.
6. reset_b pulsed low between edges mid-word with out_valid=1 -> data_out=0, out_valid=0, bit_count=0 immediately. WIDTH=12 after release: 12 bits of 12'hABC -> data_out=12'hABC.
